// File: rtl/params_pkg.sv
// params_pkg: default widths/depths and the request entry type
// shared by the mbm read front-end and its bench.
package params_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int REQ_D  = 4;
    localparam int RESP_D = 4;
    localparam int STAT_W = 32;

    typedef logic [ADDR_W-1:0] req_entry_t;

endpackage

// File: rtl/mbm_sync_fifo.sv
// mbm_sync_fifo: single-clock FIFO, power-of-2 depth, accepts
// push+pop together even when full; dout reads 0 while empty.
module mbm_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    // storage write; contents are only observed while non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // pointers wrap naturally, count tracks occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mbm_read_frontend.sv
// mbm_read_frontend: queues read addresses, issues them under a
// response credit, returns data in order. Stats: MBM_READ_FRONTEND_STATS_EN.
module mbm_read_frontend
    import params_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int REQ_DEPTH  = REQ_D,
    parameter int RESP_DEPTH = RESP_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_dvalid,
    input  logic                  s_dready,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_avalid,
    input  logic                  r_aready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic                  r_dvalid,
    output logic                  err_unexpected
`ifdef MBM_READ_FRONTEND_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_issued,
    output logic [STAT_W-1:0]     stat_stall
`endif
);

    localparam int QW = $clog2(REQ_DEPTH) + 1;
    localparam int RW = $clog2(RESP_DEPTH) + 1;

    logic          live;
    logic [QW-1:0] req_count;
    logic          req_full;
    logic          req_empty;
    logic [RW-1:0] resp_count;
    logic          resp_full;
    logic          resp_empty;
    logic [RW-1:0] outstanding;
    logic [RW:0]   in_use;
    logic          credit;
    logic          accept;
    logic          issue;
    logic          expected;
    logic          take;

    assign s_ready  = live && !req_full
                      && (req_count < QW'(REQ_DEPTH));
    assign accept   = s_valid && s_ready;
    assign in_use   = {1'b0, outstanding} + {1'b0, resp_count};
    assign credit   = !resp_full && (in_use < (RW+1)'(RESP_DEPTH));
    assign r_avalid = !req_empty && credit;
    assign issue    = r_avalid && r_aready;
    assign expected = (outstanding != '0);
    assign take     = r_dvalid && expected;
    assign s_dvalid = !resp_empty;

    mbm_sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (REQ_DEPTH)
    ) u_req (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (issue),
        .din   (s_addr),
        .dout  (r_addr),
        .count (req_count),
        .full  (req_full),
        .empty (req_empty)
    );

    mbm_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp (
        .clk   (clk),
        .rst   (rst),
        .push  (take),
        .pop   (s_dready),
        .din   (r_data),
        .dout  (s_data),
        .count (resp_count),
        .full  (resp_full),
        .empty (resp_empty)
    );

    // s_ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live <= 1'b0;
        else      live <= 1'b1;
    end

    // outstanding reads; stray data is dropped and flagged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding    <= '0;
            err_unexpected <= 1'b0;
        end else begin
            case ({issue, take})
                2'b10:   outstanding <= outstanding + RW'(1);
                2'b01:   outstanding <= outstanding - RW'(1);
                default: outstanding <= outstanding;
            endcase
            if (r_dvalid && !expected) err_unexpected <= 1'b1;
        end
    end

`ifdef MBM_READ_FRONTEND_STATS_EN
    logic stall;

    assign stall = !req_empty && !r_avalid;

    // saturating issue and credit-stall counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1))
                stat_issued <= stat_issued + STAT_W'(1);
            if (stall && (stat_stall != '1))
                stat_stall <= stat_stall + STAT_W'(1);
        end
    end
`else
    // statistics counters are not built
`endif

endmodule
